// File: rtl/func_sum_accumulator.sv
// Buffers single-precision results in a small FIFO and folds them into a running
// float sum through a six-state truncating IEEE-754 adder.
module func_sum_accumulator #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               data_valid,
    input  logic [31:0]        data_in,
    output logic [31:0]        sum,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               idle,
    output logic               overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK
    } state_t;

    state_t state;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;

    logic [31:0]   op_q;
    logic          nan_q, zero_q, eff_sub;
    logic          sa, sb, sx;
    logic [7:0]    ea, eb, ex;
    logic [23:0]   ma, mb, mx, my, mn;
    logic [24:0]   mr;
    logic signed [9:0] en;

    logic          pop_c, push_c, drop_c;
    logic [CW-1:0] cnt_nxt_c;
    logic          b_big_c;
    logic [7:0]    diff_c;
    logic [23:0]   small_c, mshift_c;
    logic [4:0]    lz_c;

    // Leading-zero count of a 24-bit mantissa; 24 when all zero.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    always_comb begin
        pop_c     = (state == S_IDLE) && (fifo_cnt != '0);
        push_c    = data_valid && ((fifo_cnt != DEPTH_C) || pop_c);
        drop_c    = data_valid && !push_c;
        cnt_nxt_c = fifo_cnt + CW'(push_c) - CW'(pop_c);
        b_big_c   = {eb, mb} > {ea, ma};
        diff_c    = b_big_c ? (eb - ea) : (ea - eb);
        small_c   = b_big_c ? ma : mb;
        mshift_c  = (diff_c >= 8'd25) ? 24'd0 : (small_c >> diff_c);
        lz_c      = lzc24(mr[23:0]);
    end

    // FIFO storage needs no reset; pointers and occupancy guard it.
    always_ff @(posedge clk) begin
        if (push_c && !reset && !clear) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            sum      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            full     <= 1'b0;
            idle     <= 1'b1;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            if (drop_c) overflow <= 1'b1;
            fifo_cnt <= cnt_nxt_c;
            full     <= (cnt_nxt_c == DEPTH_C);
            idle     <= (cnt_nxt_c == '0) &&
                        ((state == S_PACK) || ((state == S_IDLE) && !pop_c));
            case (state)
                S_IDLE: begin
                    if (pop_c) begin
                        op_q  <= mem[rd_ptr];
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    nan_q <= (op_q[30:23] == 8'hFF) ||
                             ((sum[30:23] == 8'hFF) && (sum[22:0] != '0));
                    sa    <= sum[31];
                    ea    <= sum[30:23];
                    ma    <= (sum[30:23] == '0) ? 24'd0 : {1'b1, sum[22:0]};
                    sb    <= op_q[31];
                    eb    <= op_q[30:23];
                    mb    <= (op_q[30:23] == '0) ? 24'd0 : {1'b1, op_q[22:0]};
                    state <= S_ALIGN;
                end
                S_ALIGN: begin
                    sx      <= b_big_c ? sb : sa;
                    ex      <= b_big_c ? eb : ea;
                    mx      <= b_big_c ? mb : ma;
                    my      <= mshift_c;
                    eff_sub <= sa ^ sb;
                    state   <= S_ADD;
                end
                S_ADD: begin
                    mr    <= eff_sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
                    state <= S_NORM;
                end
                S_NORM: begin
                    zero_q <= (mr == '0);
                    if (mr[24]) begin
                        mn <= mr[24:1];
                        en <= $signed({2'b00, ex}) + 10'sd1;
                    end else begin
                        mn <= mr[23:0] << lz_c;
                        en <= $signed({2'b00, ex}) - $signed({5'b00000, lz_c});
                    end
                    state <= S_PACK;
                end
                S_PACK: begin
                    if (nan_q)               sum <= QNAN;
                    else if (zero_q)         sum <= '0;
                    else if (en >= 10'sd255) sum <= {sx, 8'hFF, 23'd0};
                    else if (en <= 10'sd0)   sum <= '0;
                    else                     sum <= {sx, en[7:0], mn[22:0]};
                    if (count != '1) count <= count + COUNT_W'(1);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_func_sum_accumulator.sv
// Directed bench: queue-level reference model checked every cycle, plus literal expectations.
module tb_func_sum_accumulator;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 16;

    logic            clk;
    logic            reset, clear, data_valid;
    logic [31:0]     data_in;
    logic [31:0]     sum;
    logic [CNTW-1:0] count;
    logic            full, idle, overflow;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    func_sum_accumulator #(.FIFO_DEPTH(DEPTH), .COUNT_W(CNTW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .data_valid(data_valid),
        .data_in(data_in), .sum(sum), .count(count), .full(full),
        .idle(idle), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference float add: truncating, flush-to-zero, NaN on inf/NaN inputs.
    function automatic logic [31:0] fadd(input logic [31:0] s, input logic [31:0] x);
        int ea, eb, e, d, t;
        longint ma, mb, r, tm;
        logic sa, sb, ts;
        if (x[30:23] == 8'hFF || (s[30:23] == 8'hFF && s[22:0] != 23'd0)) return 32'h7FC0_0000;
        sa = s[31]; ea = int'(s[30:23]); ma = (ea == 0) ? 64'd0 : longint'({1'b1, s[22:0]});
        sb = x[31]; eb = int'(x[30:23]); mb = (eb == 0) ? 64'd0 : longint'({1'b1, x[22:0]});
        if (eb > ea || (eb == ea && mb > ma)) begin
            ts = sa; sa = sb; sb = ts;
            t = ea; ea = eb; eb = t;
            tm = ma; ma = mb; mb = tm;
        end
        d  = ea - eb;
        mb = (d >= 25) ? 64'd0 : (mb >> d);
        r  = (sa == sb) ? ma + mb : ma - mb;
        if (r == 0) return 32'h0;
        e = ea;
        while (r >= 64'd16777216) begin r = r >> 1; e++; end
        while (r < 64'd8388608) begin r = r << 1; e--; end
        if (e >= 255) return {sa, 8'hFF, 23'd0};
        if (e <= 0) return 32'h0;
        return {sa, 8'(e), 23'(r)};
    endfunction

    // Model state: FIFO as a queue, adder as a countdown of busy cycles.
    logic [31:0] q[$];
    logic [31:0] m_sum, m_op;
    int          m_cnt, m_phase;
    bit          m_ovf;

    always @(posedge clk) begin
        if (reset || clear) begin
            q.delete();
            m_sum = 32'h0; m_cnt = 0; m_ovf = 0; m_phase = 0;
        end else begin
            if (m_phase == 5) begin
                m_sum = fadd(m_sum, m_op);
                if (m_cnt < 65535) m_cnt++;
                m_phase = 0;
            end else if (m_phase > 0) begin
                m_phase++;
            end else if (q.size() > 0) begin
                m_op = q.pop_front();
                m_phase = 1;
            end
            if (data_valid) begin
                if (q.size() < DEPTH) q.push_back(data_in);
                else m_ovf = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model sum", sum, m_sum);
            chk("model count", 32'(count), 32'(m_cnt));
            chk("model full", 32'(full), 32'(q.size() == DEPTH));
            chk("model idle", 32'(idle), 32'(m_phase == 0 && q.size() == 0));
            chk("model overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic push(input logic [31:0] d);
        data_valid = 1'b1; data_in = d;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (!idle && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_idle: idle still %b after %0d cycles, expected 1", idle, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; clear = 1'b0; data_valid = 1'b0; data_in = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        check_en = 1;
        chk("reset sum", sum, 32'h0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset idle", 32'(idle), 32'd1);
        chk("reset full", 32'(full), 32'd0);

        // Single 1.0: busy during edges 1-5, result at edge 6.
        push(32'h3F80_0000);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("latency idle low", 32'(idle), 32'd0);
            chk("latency sum held", sum, 32'h0);
        end
        @(negedge clk);
        chk("edge6 sum", sum, 32'h3F80_0000);
        chk("edge6 count", 32'(count), 32'd1);
        chk("edge6 idle", 32'(idle), 32'd1);

        // 1.0 + 2.0 + 0.5 = 3.5
        pulse_clear();
        push(32'h3F80_0000); push(32'h4000_0000); push(32'h3F00_0000);
        wait_idle();
        chk("3.5 sum", sum, 32'h4060_0000);
        chk("3.5 count", 32'(count), 32'd3);
        chk("3.5 overflow", 32'(overflow), 32'd0);

        // Exact cancellation gives +0
        pulse_clear();
        push(32'h3F80_0000); push(32'hBF80_0000);
        wait_idle();
        chk("cancel sum", sum, 32'h0);
        chk("cancel count", 32'(count), 32'd2);

        // Seven back-to-back pushes: two dropped
        pulse_clear();
        for (int i = 0; i <= 6; i++) begin
            data_valid = 1'b1; data_in = 32'h3F80_0000;
            @(negedge clk);
            if (i == 4) chk("full after edge4", 32'(full), 32'd1);
        end
        data_valid = 1'b0;
        wait_idle();
        chk("burst sum", sum, 32'h40A0_0000);
        chk("burst count", 32'(count), 32'd5);
        chk("burst overflow", 32'(overflow), 32'd1);

        // Infinity input poisons the sum until clear
        pulse_clear();
        push(32'h7F80_0000); push(32'h3F80_0000);
        wait_idle();
        chk("nan sum", sum, 32'h7FC0_0000);
        pulse_clear();
        chk("nan clear sum", sum, 32'h0);
        chk("nan clear count", 32'(count), 32'd0);
        push(32'h4000_0000);
        wait_idle();
        chk("after nan sum", sum, 32'h4000_0000);

        // Mixed signs and different exponents: 2.0 + -0.5 = 1.5, then + 2.25 = 3.75
        pulse_clear();
        push(32'h4000_0000); push(32'hBF00_0000);
        wait_idle();
        chk("sub sum", sum, 32'h3FC0_0000);
        push(32'h4010_0000);
        wait_idle();
        chk("1.5+2.25 sum", sum, 32'h4070_0000);

        // Largest finite + itself overflows to +inf
        pulse_clear();
        push(32'h7F7F_FFFF); push(32'h7F7F_FFFF);
        wait_idle();
        chk("inf overflow sum", sum, 32'h7F80_0000);

        // data_valid on a clear edge is discarded
        clear = 1'b1; data_valid = 1'b1; data_in = 32'h3F80_0000;
        @(negedge clk);
        clear = 1'b0; data_valid = 1'b0;
        chk("clear+valid idle", 32'(idle), 32'd1);
        chk("clear+valid overflow", 32'(overflow), 32'd0);
        repeat (8) @(negedge clk);
        chk("clear+valid count", 32'(count), 32'd0);

        // Reset at edge 3 aborts the in-flight add
        push(32'h3F80_0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort sum", sum, 32'h0);
        chk("abort count", 32'(count), 32'd0);
        chk("abort idle", 32'(idle), 32'd1);
        repeat (8) @(negedge clk);
        chk("abort sum later", sum, 32'h0);
        chk("abort idle later", 32'(idle), 32'd1);

        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
